// File: rtl/lock_seq_ctrl.sv
// lock_seq_ctrl: password-lock sequencer (code entry, compare, open, password change, lockout).
// Optional master-code override is enabled by defining LOCK_SEQ_MASTER_PW_EN.
module lock_seq_ctrl #(
  parameter int unsigned         DIGITS     = 4,
  parameter int unsigned         MAX_ERR    = 3,
  parameter int unsigned         UNLOCK_CYC = 1000,
  parameter int unsigned         LOCK_CYC   = 5000,
  parameter logic [DIGITS*4-1:0] DEFAULT_PW = 16'h1234
`ifdef LOCK_SEQ_MASTER_PW_EN
  ,
  parameter logic [DIGITS*4-1:0] MASTER_PW  = 16'h9999
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dig_in,
  input  logic       dig_vld,
  input  logic       back,
  input  logic       set_req,
  output logic       entry_clr,
  output logic       unlocked,
  output logic       alarm,
  output logic       setting,
  output logic [1:0] err_cnt,
  output logic [2:0] state
);

  localparam int unsigned BUF_W  = DIGITS * 4;
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
  localparam int unsigned TMR_W  = 24;
  localparam int unsigned ERR_W  = 2;
  localparam int unsigned ERR_IW = ERR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ENTRY     = 3'd1,
    ST_CHECK     = 3'd2,
    ST_OPEN      = 3'd3,
    ST_SET_ENTRY = 3'd4,
    ST_COMMIT    = 3'd5,
    ST_LOCKOUT   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   code_q, code_d;
  logic [BUF_W-1:0]   pw_q, pw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               entry_clr_q, entry_clr_d;
  logic               unlocked_q, unlocked_d;
  logic               alarm_q, alarm_d;
  logic               setting_q, setting_d;

  logic [BUF_W-1:0]   code_shift;
  logic               last_dig;
  logic [ERR_IW-1:0]  err_inc;
  logic               pw_match;

  assign code_shift = BUF_W'(code_q << 4) | BUF_W'(dig_in);
  assign last_dig   = (cnt_q == CNT_W'(DIGITS - 1));
  assign err_inc    = {1'b0, err_cnt_q} + ERR_IW'(1);
`ifdef LOCK_SEQ_MASTER_PW_EN
  assign pw_match   = (code_q == pw_q) || (code_q == MASTER_PW);
`else
  assign pw_match   = (code_q == pw_q);
`endif

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    pw_d        = pw_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    err_cnt_d   = err_cnt_q;
    entry_clr_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_ENTRY, ST_SET_ENTRY: begin
        if (dig_vld) begin
          code_d = code_shift;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_dig) begin
            state_d = (state_q == ST_SET_ENTRY) ? ST_COMMIT : ST_CHECK;
          end else if (state_q == ST_IDLE) begin
            state_d = ST_ENTRY;
          end
        end else if (back && (state_q != ST_IDLE) && (cnt_q != '0)) begin
          code_d = code_q >> 4;
          cnt_d  = cnt_q - CNT_W'(1);
          if ((state_q == ST_ENTRY) && (cnt_q == CNT_W'(1))) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_CHECK: begin
        entry_clr_d = 1'b1;
        code_d      = '0;
        cnt_d       = '0;
        if (pw_match) begin
          state_d   = ST_OPEN;
          err_cnt_d = '0;
          timer_d   = TMR_W'(UNLOCK_CYC - 1);
        end else begin
          err_cnt_d = err_inc[ERR_W-1:0];
          if (err_inc >= ERR_IW'(MAX_ERR)) begin
            state_d = ST_LOCKOUT;
            timer_d = TMR_W'(LOCK_CYC - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      // A password-change request outranks the relock timeout
      ST_OPEN: begin
        timer_d = timer_q - TMR_W'(1);
        if (set_req) begin
          state_d     = ST_SET_ENTRY;
          code_d      = '0;
          cnt_d       = '0;
          entry_clr_d = 1'b1;
        end else if (timer_q == '0) begin
          state_d     = ST_IDLE;
          entry_clr_d = 1'b1;
        end
      end

      ST_COMMIT: begin
        pw_d        = code_q;
        code_d      = '0;
        cnt_d       = '0;
        entry_clr_d = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d     = ST_IDLE;
          err_cnt_d   = '0;
          entry_clr_d = 1'b1;
          code_d      = '0;
          cnt_d       = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
`ifdef LOCK_SEQ_MASTER_PW_EN
        // Digits are gathered here only to detect the master abort code
        if (dig_vld) begin
          if (last_dig) begin
            code_d = '0;
            cnt_d  = '0;
            if (code_shift == MASTER_PW) begin
              state_d     = ST_IDLE;
              err_cnt_d   = '0;
              entry_clr_d = 1'b1;
            end
          end else if (timer_q != '0) begin
            code_d = code_shift;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
        code_d  = '0;
        cnt_d   = '0;
      end
    endcase

    unlocked_d = (state_d == ST_OPEN);
    alarm_d    = (state_d == ST_LOCKOUT);
    setting_d  = (state_d == ST_SET_ENTRY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      pw_q        <= DEFAULT_PW;
      cnt_q       <= '0;
      timer_q     <= '0;
      err_cnt_q   <= '0;
      entry_clr_q <= 1'b0;
      unlocked_q  <= 1'b0;
      alarm_q     <= 1'b0;
      setting_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      pw_q        <= pw_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      err_cnt_q   <= err_cnt_d;
      entry_clr_q <= entry_clr_d;
      unlocked_q  <= unlocked_d;
      alarm_q     <= alarm_d;
      setting_q   <= setting_d;
    end
  end

  assign entry_clr = entry_clr_q;
  assign unlocked  = unlocked_q;
  assign alarm     = alarm_q;
  assign setting   = setting_q;
  assign err_cnt   = err_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Bench for lock_seq_ctrl: cycle-by-cycle comparison against a digit-queue model plus directed literal checks.
module tb_lock_seq_ctrl;

  localparam int unsigned UNLOCK_CYC = 8;
  localparam int unsigned LOCK_CYC   = 16;
  localparam int          ND         = 4;
  localparam int          MAXE       = 3;
  localparam int          DEF_PW     = 'h1234;
  localparam int          MASTER     = 'h9999;
`ifdef LOCK_SEQ_MASTER_PW_EN
  localparam bit          MASTER_EN  = 1'b1;
`else
  localparam bit          MASTER_EN  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dig_in;
  logic       dig_vld;
  logic       back;
  logic       set_req;
  logic       entry_clr;
  logic       unlocked;
  logic       alarm;
  logic       setting;
  logic [1:0] err_cnt;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  lock_seq_ctrl #(
    .DIGITS    (4),
    .MAX_ERR   (3),
    .UNLOCK_CYC(UNLOCK_CYC),
    .LOCK_CYC  (LOCK_CYC),
    .DEFAULT_PW(16'h1234)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dig_in   (dig_in),
    .dig_vld  (dig_vld),
    .back     (back),
    .set_req  (set_req),
    .entry_clr(entry_clr),
    .unlocked (unlocked),
    .alarm    (alarm),
    .setting  (setting),
    .err_cnt  (err_cnt),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: the entered code is a queue of digits; each mode has a remaining-cycle budget
  int q[$];
  int m_state, m_err, m_left, m_pw, m_code;
  bit m_clr;

  function automatic int qval();
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_state = 0; m_err = 0; m_left = 0; m_pw = DEF_PW; m_clr = 1'b0;
      q.delete();
    end else begin
      m_clr = 1'b0;
      case (m_state)
        0, 1, 4: begin
          if (dig_vld) begin
            q.push_back(int'(dig_in));
            if (q.size() == ND) m_state = (m_state == 4) ? 5 : 2;
            else if (m_state == 0) m_state = 1;
          end else if (back && m_state != 0 && q.size() > 0) begin
            void'(q.pop_back());
            if (m_state == 1 && q.size() == 0) m_state = 0;
          end
        end
        2: begin
          m_code = qval();
          q.delete();
          m_clr = 1'b1;
          if (m_code == m_pw || (MASTER_EN && m_code == MASTER)) begin
            m_state = 3; m_err = 0; m_left = int'(UNLOCK_CYC);
          end else begin
            m_err++;
            if (m_err >= MAXE) begin
              m_state = 6; m_left = int'(LOCK_CYC);
            end else begin
              m_state = 0;
            end
          end
        end
        3: begin
          m_left--;
          if (set_req) begin
            m_state = 4; m_clr = 1'b1;
          end else if (m_left == 0) begin
            m_state = 0; m_clr = 1'b1;
          end
        end
        5: begin
          m_pw = qval();
          q.delete();
          m_clr = 1'b1;
          m_state = 0;
        end
        6: begin
          m_left--;
          if (MASTER_EN && dig_vld) begin
            q.push_back(int'(dig_in));
            if (q.size() == ND) begin
              if (qval() == MASTER) begin
                m_state = 0; m_err = 0; m_clr = 1'b1;
              end
              q.delete();
            end
          end
          if (m_left == 0) begin
            m_state = 0; m_err = 0; m_clr = 1'b1;
            q.delete();
          end
        end
        default: m_state = 0;
      endcase
    end
  end

  // Every-cycle compare of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [9:0] act_v, exp_v;
      act_v = {state, unlocked, alarm, setting, err_cnt, entry_clr};
      exp_v = {3'(m_state), m_state == 3, m_state == 6, m_state == 4, 2'(m_err), m_clr};
      check($sformatf("model_cyc%0d", cyc), int'(act_v), int'(exp_v));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic digit(input int d);
    dig_in  = 4'(d);
    dig_vld = 1'b1;
    wait_cyc(1);
    dig_vld = 1'b0;
  endtask

  task automatic enter_code(input int code);
    for (int i = ND - 1; i >= 0; i--) digit((code >> (4 * i)) & 15);
  endtask

  task automatic press_back();
    back = 1'b1;
    wait_cyc(1);
    back = 1'b0;
  endtask

  task automatic press_set();
    set_req = 1'b1;
    wait_cyc(1);
    set_req = 1'b0;
  endtask

  initial begin
    int ucount, ccount, acount;
    rst = 1'b1; dig_in = 4'd0; dig_vld = 1'b0; back = 1'b0; set_req = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_outputs", int'({state, unlocked, alarm, setting, err_cnt, entry_clr}), 0);
    wait_cyc(1);
    rst = 1'b0;

    // Correct code opens for exactly UNLOCK_CYC cycles
    enter_code('h1234);
    check("check_after_4th", int'(state), 2);
    wait_cyc(1);
    check("open_state", int'(state), 3);
    check("open_err", int'(err_cnt), 0);
    ucount = 0; ccount = 0;
    for (int i = 0; i < 12; i++) begin
      if (unlocked) ucount++;
      if (entry_clr) ccount++;
      wait_cyc(1);
    end
    check("unlock_len", ucount, 8);
    check("clr_pulses", ccount, 2);
    check("relock_idle", int'(state), 0);

    // Backspace inside a code
    digit(1); digit(2); digit(5); press_back(); digit(3); digit(4);
    check("back_check", int'(state), 2);
    wait_cyc(1);
    check("back_open", int'(state), 3);
    wait_cyc(10);

    // dig_vld and back together: the digit is kept and back is dropped
    digit(1); digit(2);
    dig_in = 4'd3; dig_vld = 1'b1; back = 1'b1;
    wait_cyc(1);
    dig_vld = 1'b0; back = 1'b0;
    digit(4);
    wait_cyc(1);
    check("vld_back_prio", int'(state), 3);
    wait_cyc(10);

    // Three failures then lockout, ignoring digits while locked
    enter_code('h0000); wait_cyc(1);
    check("err1", int'(err_cnt), 1);
    enter_code('h0000); wait_cyc(1);
    check("err2", int'(err_cnt), 2);
    enter_code('h0000); wait_cyc(1);
    check("err3", int'(err_cnt), 3);
    check("lockout_state", int'(state), 6);
    acount = 0;
    for (int i = 0; i < 25; i++) begin
      if (alarm) acount++;
      dig_in  = 4'(i % 10);
      dig_vld = (i < 14) && (i % 2 == 0);
      wait_cyc(1);
    end
    dig_vld = 1'b0;
    check("alarm_len", acount, 16);
    check("lockout_exit_state", int'(state), 0);
    check("lockout_exit_err", int'(err_cnt), 0);

    // Change password to 5678
    enter_code('h1234); wait_cyc(1);
    press_set();
    check("set_state", int'(state), 4);
    check("set_flag", int'(setting), 1);
    enter_code('h5678);
    check("commit_state", int'(state), 5);
    wait_cyc(1);
    check("commit_clr", int'(entry_clr), 1);
    enter_code('h1234); wait_cyc(1);
    check("old_pw_fails", int'(err_cnt), 1);
    enter_code('h5678); wait_cyc(1);
    check("new_pw_opens", int'(state), 3);
    check("new_pw_err", int'(err_cnt), 0);
    wait_cyc(10);

    // Reset in the middle of a password change restores the default
    enter_code('h5678); wait_cyc(1);
    press_set();
    digit(9); digit(8);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check("midset_reset", int'({state, unlocked, alarm, setting, err_cnt, entry_clr}), 0);
    enter_code('h1234); wait_cyc(1);
    check("default_restored", int'(state), 3);
    wait_cyc(10);

    // Master code is a match only when the feature is built in
    enter_code('h9999); wait_cyc(1);
    check("master_in_check", int'(state), MASTER_EN ? 3 : 0);
    wait_cyc(10);

`ifdef LOCK_SEQ_MASTER_PW_EN
    enter_code('h0000); wait_cyc(1);
    enter_code('h0000); wait_cyc(1);
    enter_code('h0000); wait_cyc(1);
    check("m_lockout", int'(state), 6);
    enter_code('h9999);
    check("m_abort_state", int'(state), 0);
    check("m_abort_alarm", int'(alarm), 0);
    check("m_abort_err", int'(err_cnt), 0);
    wait_cyc(3);
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
